// File: rtl/aurora_cdc_pkg.sv
// Shared constants for the Aurora clock-domain-crossing synchronizers:
// transfer-type encodings, synchronizer depth limits and a parameter sanity check.
package aurora_cdc_pkg;

  localparam int CDC_PULSE       = 0;
  localparam int CDC_LEVEL       = 1;
  localparam int CDC_LEVEL_ACK   = 2;

  localparam int MTBF_STAGES_MIN = 2;
  localparam int MTBF_STAGES_MAX = 6;
  localparam int VECTOR_W_MIN    = 1;
  localparam int VECTOR_W_MAX    = 32;

  function automatic bit cdc_params_ok(
    input int cdc_type,
    input int flop_input,
    input int reset_state,
    input int single_bit,
    input int vector_width,
    input int mtbf_stages
  );
    bit ok;
    ok = 1'b1;
    if (cdc_type < CDC_PULSE || cdc_type > CDC_LEVEL_ACK)                    ok = 1'b0;
    if (flop_input < 0 || flop_input > 1)                                    ok = 1'b0;
    if (reset_state < 0 || reset_state > 1)                                  ok = 1'b0;
    if (single_bit < 0 || single_bit > 1)                                    ok = 1'b0;
    if (vector_width < VECTOR_W_MIN || vector_width > VECTOR_W_MAX)          ok = 1'b0;
    if (mtbf_stages < MTBF_STAGES_MIN || mtbf_stages > MTBF_STAGES_MAX)      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/cdc_sync_stage.sv
// N-deep single-bit synchronizer chain with an optional synchronous active-low clear.
// Used for the forward level/toggle path, the acknowledge return path and each vector bit.
module cdc_sync_stage
  import aurora_cdc_pkg::*;
#(
  parameter int STAGES   = 2,
  parameter bit RESET_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < MTBF_STAGES_MIN || STAGES > MTBF_STAGES_MAX) begin : g_depth_check
    $error("cdc_sync_stage: STAGES out of range");
  end

  (* ASYNC_REG = "true", SHREG_EXTRACT = "no" *) logic [STAGES-1:0] sync_q = '0;

  always_ff @(posedge clk) begin
    if (RESET_EN && !rst_n) sync_q <= '0;
    else                    sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/aurora_8b10b_0_cdc_sync_exdes.sv
// Pulse / level / level-with-ack synchronizer from the primary (INIT_CLK) domain into
// USER_CLK, used on the Aurora support reset path to produce gt_rst_sync.
module aurora_8b10b_0_cdc_sync_exdes
  import aurora_cdc_pkg::*;
#(
  parameter int c_cdc_type     = 1,
  parameter int c_flop_input   = 0,
  parameter int c_reset_state  = 0,
  parameter int c_single_bit   = 1,
  parameter int c_vector_width = 32,
  parameter int c_mtbf_stages  = 2
) (
  input  logic                      scndry_aclk,
  input  logic                      scndry_rst_n,
  input  logic                      prmry_aclk,
  input  logic                      prmry_rst_n,
  input  logic                      prmry_in,
  input  logic [c_vector_width-1:0] prmry_vect_in,
  output logic                      prmry_ack,
  output logic                      scndry_out,
  output logic [c_vector_width-1:0] scndry_vect_out
);

  localparam bit RST_EN  = (c_reset_state == 1);
  localparam bit FLOP_IN = (c_flop_input == 1);

  if (!cdc_params_ok(c_cdc_type, c_flop_input, c_reset_state, c_single_bit,
                     c_vector_width, c_mtbf_stages)) begin : g_param_check
    $error("aurora_8b10b_0_cdc_sync_exdes: parameter out of range");
  end

  logic prmry_clr;
  logic scndry_clr;
  assign prmry_clr  = RST_EN && !prmry_rst_n;
  assign scndry_clr = RST_EN && !scndry_rst_n;

  // Depending on the mode some inputs are intentionally not consumed.
  logic unused_sink;
  assign unused_sink = ^{prmry_in, prmry_vect_in, prmry_clr, scndry_clr};

  if (c_single_bit == 1) begin : g_single
    logic src_lvl;
    logic fwd_bit;
    logic fwd_sync;

    assign scndry_vect_out = '0;

    // Stage p0: optional primary-domain capture of the source bit
    if (FLOP_IN) begin : g_flop
      logic in_q_p0 = 1'b0;
      always_ff @(posedge prmry_aclk) begin
        if (prmry_clr) in_q_p0 <= 1'b0;
        else           in_q_p0 <= prmry_in;
      end
      assign src_lvl = in_q_p0;
    end else begin : g_direct
      assign src_lvl = prmry_in;
    end

    // Stage p1: rising-edge detect folded into a toggle for pulse transfers
    if (c_cdc_type == CDC_PULSE) begin : g_toggle
      logic src_d_p1 = 1'b0;
      logic tgl_p1   = 1'b0;
      always_ff @(posedge prmry_aclk) begin
        if (prmry_clr) begin
          src_d_p1 <= 1'b0;
          tgl_p1   <= 1'b0;
        end else begin
          src_d_p1 <= src_lvl;
          if (src_lvl && !src_d_p1) tgl_p1 <= !tgl_p1;
        end
      end
      assign fwd_bit = tgl_p1;
    end else begin : g_level_src
      assign fwd_bit = src_lvl;
    end

    cdc_sync_stage #(
      .STAGES   (c_mtbf_stages),
      .RESET_EN (RST_EN)
    ) u_fwd_sync (
      .clk   (scndry_aclk),
      .rst_n (scndry_rst_n),
      .d     (fwd_bit),
      .q     (fwd_sync)
    );

    // Stage p2: destination-side output formation
    if (c_cdc_type == CDC_PULSE) begin : g_pulse_out
      localparam logic [2:0] WARM_LOAD = 3'(c_mtbf_stages + 1);
      logic       fwd_d_p2 = 1'b0;
      logic [2:0] warm_p2  = 3'd0;

      // After a destination clear the chain refills with the stale toggle; the
      // warm-up count masks that refill so an in-flight pulse is dropped cleanly.
      always_ff @(posedge scndry_aclk) begin
        if (scndry_clr) begin
          fwd_d_p2 <= 1'b0;
          warm_p2  <= WARM_LOAD;
        end else begin
          fwd_d_p2 <= fwd_sync;
          if (warm_p2 != 3'd0) warm_p2 <= warm_p2 - 3'd1;
        end
      end

      assign scndry_out = (fwd_sync ^ fwd_d_p2) && (warm_p2 == 3'd0);
      assign prmry_ack  = 1'b0;
    end else if (c_cdc_type == CDC_LEVEL_ACK) begin : g_ack
      logic ret_sync;
      logic ret_d_p2 = 1'b0;

      cdc_sync_stage #(
        .STAGES   (c_mtbf_stages),
        .RESET_EN (RST_EN)
      ) u_ret_sync (
        .clk   (prmry_aclk),
        .rst_n (prmry_rst_n),
        .d     (fwd_sync),
        .q     (ret_sync)
      );

      always_ff @(posedge prmry_aclk) begin
        if (prmry_clr) ret_d_p2 <= 1'b0;
        else           ret_d_p2 <= ret_sync;
      end

      assign prmry_ack  = ret_sync ^ ret_d_p2;
      assign scndry_out = fwd_sync;
    end else begin : g_level_out
      assign scndry_out = fwd_sync;
      assign prmry_ack  = 1'b0;
    end
  end else begin : g_vector
    logic [c_vector_width-1:0] vsrc;

    // Stage p0: optional primary-domain capture of the whole vector
    if (FLOP_IN) begin : g_vflop
      logic [c_vector_width-1:0] vin_q_p0 = '0;
      always_ff @(posedge prmry_aclk) begin
        if (prmry_clr) vin_q_p0 <= '0;
        else           vin_q_p0 <= prmry_vect_in;
      end
      assign vsrc = vin_q_p0;
    end else begin : g_vdirect
      assign vsrc = prmry_vect_in;
    end

    // Each bit crosses independently; the source must be quasi-static or Gray-coded.
    for (genvar i = 0; i < c_vector_width; i++) begin : g_bit
      cdc_sync_stage #(
        .STAGES   (c_mtbf_stages),
        .RESET_EN (RST_EN)
      ) u_bit_sync (
        .clk   (scndry_aclk),
        .rst_n (scndry_rst_n),
        .d     (vsrc[i]),
        .q     (scndry_vect_out[i])
      );
    end

    assign scndry_out = 1'b0;
    assign prmry_ack  = 1'b0;
  end

endmodule

// File: tb/tb_aurora_8b10b_0_cdc_sync_exdes.sv
// Scoreboard bench for the CDC synchronizer: level, flopped-input level, pulse,
// level-with-ack and vector instances share one source and one destination clock.
module tb_aurora_8b10b_0_cdc_sync_exdes;

  typedef struct {
    int val;
    int ref_cnt;
    int lat;
  } exp_t;

  logic sclk = 1'b0;
  logic pclk = 1'b0;
  int   scnt = 0;
  int   pcnt = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Destination posedges at odd times, source posedges at 2+16k; inputs are driven
  // on source negedges (even times) so no drive ever coincides with a capture edge.
  always #5 sclk = ~sclk;
  initial begin
    #2;
    forever begin
      pclk = 1'b1; #8;
      pclk = 1'b0; #8;
    end
  end
  always @(posedge sclk) scnt++;
  always @(posedge pclk) pcnt++;

  logic       prst_n = 1'b0;
  logic       lvl_srst_n = 1'b0, pls_srst_n = 1'b0;
  logic       lvl_in = 1'b0, flp_in = 1'b0, pls_in = 1'b0, ack_in = 1'b0;
  logic [1:0] vec_in = 2'b00;
  logic       lvl_out, flp_out, pls_out, ack_out, vec_out;
  logic       lvl_ack, flp_ack, pls_ack, ack_p, vec_ack;
  logic [1:0] lvl_v, flp_v, pls_v, ack_v, vec_v;

  aurora_8b10b_0_cdc_sync_exdes #(
    .c_cdc_type(1), .c_flop_input(0), .c_reset_state(1), .c_single_bit(1),
    .c_vector_width(2), .c_mtbf_stages(3)
  ) u_lvl (
    .scndry_aclk(sclk), .scndry_rst_n(lvl_srst_n), .prmry_aclk(pclk), .prmry_rst_n(prst_n),
    .prmry_in(lvl_in), .prmry_vect_in(2'b11), .prmry_ack(lvl_ack), .scndry_out(lvl_out),
    .scndry_vect_out(lvl_v)
  );

  aurora_8b10b_0_cdc_sync_exdes #(
    .c_cdc_type(1), .c_flop_input(1), .c_reset_state(0), .c_single_bit(1),
    .c_vector_width(2), .c_mtbf_stages(3)
  ) u_flp (
    .scndry_aclk(sclk), .scndry_rst_n(1'b1), .prmry_aclk(pclk), .prmry_rst_n(1'b1),
    .prmry_in(flp_in), .prmry_vect_in(2'b00), .prmry_ack(flp_ack), .scndry_out(flp_out),
    .scndry_vect_out(flp_v)
  );

  aurora_8b10b_0_cdc_sync_exdes #(
    .c_cdc_type(0), .c_flop_input(0), .c_reset_state(1), .c_single_bit(1),
    .c_vector_width(2), .c_mtbf_stages(3)
  ) u_pls (
    .scndry_aclk(sclk), .scndry_rst_n(pls_srst_n), .prmry_aclk(pclk), .prmry_rst_n(prst_n),
    .prmry_in(pls_in), .prmry_vect_in(2'b00), .prmry_ack(pls_ack), .scndry_out(pls_out),
    .scndry_vect_out(pls_v)
  );

  aurora_8b10b_0_cdc_sync_exdes #(
    .c_cdc_type(2), .c_flop_input(0), .c_reset_state(0), .c_single_bit(1),
    .c_vector_width(2), .c_mtbf_stages(3)
  ) u_ack (
    .scndry_aclk(sclk), .scndry_rst_n(1'b1), .prmry_aclk(pclk), .prmry_rst_n(1'b1),
    .prmry_in(ack_in), .prmry_vect_in(2'b00), .prmry_ack(ack_p), .scndry_out(ack_out),
    .scndry_vect_out(ack_v)
  );

  aurora_8b10b_0_cdc_sync_exdes #(
    .c_cdc_type(1), .c_flop_input(0), .c_reset_state(0), .c_single_bit(0),
    .c_vector_width(2), .c_mtbf_stages(3)
  ) u_vec (
    .scndry_aclk(sclk), .scndry_rst_n(1'b1), .prmry_aclk(pclk), .prmry_rst_n(1'b1),
    .prmry_in(1'b1), .prmry_vect_in(vec_in), .prmry_ack(vec_ack), .scndry_out(vec_out),
    .scndry_vect_out(vec_v)
  );

  exp_t q_lvl[$], q_flp[$], q_pls[$], q_ack[$], q_ackp[$], q_vec[$];

  task automatic chk_evt(input string nm, input bit have, input exp_t e, input int val, input int cnt);
    n_tests++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s: unexpected output value %0d at edge %0d, required no event", nm, val, cnt);
    end else if (val != e.val || (cnt - e.ref_cnt) != e.lat) begin
      n_fail++;
      $display("FAIL %s: got value %0d after %0d edges, required value %0d after %0d edges",
               nm, val, cnt - e.ref_cnt, e.val, e.lat);
    end
  endtask

  task automatic chk_val(input string nm, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  // Destination-side monitor: every output change pops one expected event
  logic       lvl_prev = 1'b0, flp_prev = 1'b0, ack_prev = 1'b0;
  logic [1:0] vec_prev = 2'b00;
  always @(posedge sclk) begin : mon_scndry
    exp_t e;
    bit   have;
    #2;
    if (lvl_out !== lvl_prev) begin
      have = (q_lvl.size() != 0);
      e = have ? q_lvl.pop_front() : '{0, 0, 0};
      chk_evt("lvl_out", have, e, int'(lvl_out), scnt);
      lvl_prev = lvl_out;
    end
    if (flp_out !== flp_prev) begin
      have = (q_flp.size() != 0);
      e = have ? q_flp.pop_front() : '{0, 0, 0};
      chk_evt("flp_out", have, e, int'(flp_out), scnt);
      flp_prev = flp_out;
    end
    if (pls_out === 1'b1) begin
      have = (q_pls.size() != 0);
      e = have ? q_pls.pop_front() : '{0, 0, 0};
      chk_evt("pls_out", have, e, 1, scnt);
    end
    if (ack_out !== ack_prev) begin
      have = (q_ack.size() != 0);
      e = have ? q_ack.pop_front() : '{0, 0, 0};
      chk_evt("ack_scndry_out", have, e, int'(ack_out), scnt);
      ack_prev = ack_out;
      q_ackp.push_back('{1, pcnt, 3});
    end
    if (vec_v !== vec_prev) begin
      have = (q_vec.size() != 0);
      e = have ? q_vec.pop_front() : '{0, 0, 0};
      chk_evt("vec_out", have, e, int'(vec_v), scnt);
      chk_val("vec_scndry_out", int'(vec_out), 0);
      vec_prev = vec_v;
    end
  end

  // Source-side monitor for the acknowledge pulse
  always @(posedge pclk) begin : mon_prmry
    exp_t e;
    bit   have;
    #1;
    if (ack_p === 1'b1) begin
      have = (q_ackp.size() != 0);
      e = have ? q_ackp.pop_front() : '{0, 0, 0};
      chk_evt("prmry_ack", have, e, 1, pcnt);
    end
  end

  task automatic wait_p(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_pulse(input bit expect_out);
    @(negedge pclk);
    pls_in = 1'b1;
    @(posedge pclk);
    if (expect_out) q_pls.push_back('{1, scnt, 3});
    @(negedge pclk);
    pls_in = 1'b0;
  endtask

  initial begin
    wait_p(4);
    prst_n = 1'b1; lvl_srst_n = 1'b1; pls_srst_n = 1'b1;
    wait_p(2);
    chk_val("rst_lvl_out",   int'(lvl_out), 0);
    chk_val("rst_lvl_vect",  int'(lvl_v),   0);
    chk_val("rst_lvl_ack",   int'(lvl_ack), 0);
    chk_val("rst_flp_out",   int'(flp_out), 0);
    chk_val("rst_pls_out",   int'(pls_out), 0);
    chk_val("rst_ack_out",   int'(ack_out), 0);
    chk_val("rst_ack_pulse", int'(ack_p),   0);
    chk_val("rst_vec_vect",  int'(vec_v),   0);
    chk_val("rst_vec_out",   int'(vec_out), 0);

    // Level, direct input: 3 destination edges
    lvl_in = 1'b1;
    q_lvl.push_back('{1, scnt, 3});
    wait_p(4);

    // Level, flopped input: 1 source edge then 3 destination edges
    @(negedge pclk);
    flp_in = 1'b1;
    @(posedge pclk);
    q_flp.push_back('{1, scnt, 3});
    wait_p(4);

    // Pulse: two widely spaced pulses, one dropped by a mid-flight clear, one more
    send_pulse(1'b1);
    wait_p(6);
    send_pulse(1'b1);
    wait_p(6);
    send_pulse(1'b0);
    pls_srst_n = 1'b0;
    wait_p(4);
    pls_srst_n = 1'b1;
    wait_p(6);
    send_pulse(1'b1);
    wait_p(6);

    // Level with ack: rise then fall, each returns an ack pulse
    @(negedge pclk);
    ack_in = 1'b1;
    q_ack.push_back('{1, scnt, 3});
    wait_p(8);
    ack_in = 1'b0;
    q_ack.push_back('{0, scnt, 3});
    wait_p(8);

    // Vector path
    vec_in = 2'b10;
    q_vec.push_back('{2, scnt, 3});
    wait_p(4);

    // Destination clear while the level output is high, then re-propagation
    lvl_srst_n = 1'b0;
    q_lvl.push_back('{0, scnt, 1});
    wait_p(4);
    lvl_srst_n = 1'b1;
    q_lvl.push_back('{1, scnt, 3});
    wait_p(6);

    chk_val("pending_lvl",  q_lvl.size(),  0);
    chk_val("pending_flp",  q_flp.size(),  0);
    chk_val("pending_pls",  q_pls.size(),  0);
    chk_val("pending_ack",  q_ack.size(),  0);
    chk_val("pending_ackp", q_ackp.size(), 0);
    chk_val("pending_vec",  q_vec.size(),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
